q_reg: RTL and testbench

Q_REG -- requirements
Module: q_reg

---
 rtl/q_pkg.sv | 36 +++
 rtl/q_trace_buf.sv | 48 ++++
 rtl/q_reg.sv | 70 +++++++
 tb/tb_q_reg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// Shared definitions for the Q register slice: datapath width, history depth,
// the Q-control mode encoding and the next-value rule used by the Q register.
package q_pkg;

  localparam int Q_WIDTH      = 32;
  localparam int TRACE_DEPTH  = 4;
  localparam int TRACE_PTR_W  = 2;
  localparam int TRACE_CNT_W  = 3;

  // {qs1,qs0} as presented by Q control
  typedef enum logic [1:0] {
    QMODE_HOLD = 2'b00,
    QMODE_SHL  = 2'b01,
    QMODE_SHR  = 2'b10,
    QMODE_LOAD = 2'b11
  } q_mode_t;

  // Shift-left inserts the inverted ALU sign bit (divide-step quotient bit);
  // shift-right inserts ALU bit 0 at the top (multiply-step product bit).
  function automatic logic [Q_WIDTH-1:0] next_q(
    input q_mode_t              mode,
    input logic [Q_WIDTH-1:0]   cur,
    input logic [Q_WIDTH-1:0]   alu_lo
  );
    logic [Q_WIDTH-1:0] result;
    result = cur;
    case (mode)
      QMODE_SHL:  result = {cur[Q_WIDTH-2:0], ~alu_lo[Q_WIDTH-1]};
      QMODE_SHR:  result = {alu_lo[0], cur[Q_WIDTH-1:1]};
      QMODE_LOAD: result = alu_lo;
      default:    result = cur;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/q_trace_buf.sv
// Four-entry ring of past Q values. Each push stores din at the write
// pointer; reads are combinational by age (idx 0 = most recent push) and
// return zero for ages that have not been filled yet.
module q_trace_buf
  import q_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [Q_WIDTH-1:0]     din,
  input  logic [TRACE_PTR_W-1:0] idx,
  output logic [Q_WIDTH-1:0]     dout,
  output logic [TRACE_CNT_W-1:0] cnt
);

  logic [Q_WIDTH-1:0]     mem [TRACE_DEPTH];
  logic [TRACE_PTR_W-1:0] wptr;
  logic [TRACE_PTR_W-1:0] rptr;

  // Storage, write pointer (wraps naturally at the 2-bit boundary) and a
  // fill count that stops at the ring depth once the oldest entry is reused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr <= '0;
      cnt  <= '0;
    end else if (push) begin
      mem[wptr] <= din;
      wptr      <= wptr + 1'b1;
      if (cnt != TRACE_CNT_W'(TRACE_DEPTH)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Age-indexed read: entries are counted back from the last written slot,
  // so a push on the same edge is not yet visible here.
  always_comb begin
    rptr = wptr - 1'b1 - idx;
    dout = '0;
    if ({1'b0, idx} < cnt) begin
      dout = mem[rptr];
    end
  end

endmodule

// File: rtl/q_reg.sv
// Q register: multiply/divide helper register updated once per
// microinstruction on the state_fetch strobe, with MF-bus drive and an
// optional history of pre-update values for debug.
// Build option: define Q_REG_TRACE_EN to include the history ring; without it
// trace_q and trace_cnt read as zero and no history storage exists.
module q_reg
  import q_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   state_fetch,
  input  logic                   qs0,
  input  logic                   qs1,
  input  logic                   qdrive,
  input  logic [Q_WIDTH:0]       alu,
  output logic [Q_WIDTH-1:0]     q,
  output logic [Q_WIDTH-1:0]     q_mf,
  output logic                   q_lsb,
  input  logic [TRACE_PTR_W-1:0] trace_idx,
  output logic [Q_WIDTH-1:0]     trace_q,
  output logic [TRACE_CNT_W-1:0] trace_cnt
);

  q_mode_t            mode;
  logic               update;
  logic [Q_WIDTH-1:0] q_next;
  logic               unused_bits;

  // Decode the Q-control mode and decide whether this edge is a real update;
  // a hold strobe leaves Q alone and must not disturb the history either.
  always_comb begin
    mode   = q_mode_t'({qs1, qs0});
    update = state_fetch && (mode != QMODE_HOLD);
    q_next = next_q(mode, q, alu[Q_WIDTH-1:0]);
  end

  // The Q register itself; reset wins over any strobe arriving with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (update) begin
      q <= q_next;
    end
  end

  // Bus drive and the multiply-step condition bit come straight off Q.
  always_comb begin
    q_mf  = qdrive ? q : '0;
    q_lsb = q[0];
  end

`ifdef Q_REG_TRACE_EN
  q_trace_buf u_trace (
    .clk   (clk),
    .reset (reset),
    .push  (update),
    .din   (q),
    .idx   (trace_idx),
    .dout  (trace_q),
    .cnt   (trace_cnt)
  );

  assign unused_bits = alu[Q_WIDTH];
`else
  assign trace_q     = '0;
  assign trace_cnt   = '0;
  assign unused_bits = ^{alu[Q_WIDTH], trace_idx};
`endif

endmodule

// File: tb/tb_q_reg.sv
// Self-checking bench for q_reg: directed vector table, ring-wrap and
// reset-during-strobe sequences, then randomized traffic against a
// behavioural model (Q as integer arithmetic, history as a queue).
// Honours Q_REG_TRACE_EN the same way the design does.
module tb_q_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        state_fetch;
  logic        qs0;
  logic        qs1;
  logic        qdrive;
  logic [32:0] alu;
  logic [31:0] q;
  logic [31:0] q_mf;
  logic        q_lsb;
  logic [1:0]  trace_idx;
  logic [31:0] trace_q;
  logic [2:0]  trace_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq;
  logic [31:0] hist [$];

  typedef struct {
    logic        fetch;
    logic [1:0]  mode;
    logic [32:0] alu;
    logic        qdrive;
    logic [31:0] exp_q;
    logic [31:0] exp_mf;
    logic        exp_lsb;
  } vec_t;

  vec_t vecs [10];

  q_reg dut (
    .clk         (clk),
    .reset       (reset),
    .state_fetch (state_fetch),
    .qs0         (qs0),
    .qs1         (qs1),
    .qdrive      (qdrive),
    .alu         (alu),
    .q           (q),
    .q_mf        (q_mf),
    .q_lsb       (q_lsb),
    .trace_idx   (trace_idx),
    .trace_q     (trace_q),
    .trace_cnt   (trace_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expTrace(input int idx);
`ifdef Q_REG_TRACE_EN
    if (idx < hist.size()) return hist[idx];
`endif
    return 32'h0;
  endfunction

  function automatic logic [31:0] expCnt();
`ifdef Q_REG_TRACE_EN
    return 32'(hist.size());
`else
    return 32'h0;
`endif
  endfunction

  task automatic modelReset();
    mq = 32'h0;
    hist.delete();
  endtask

  // Advance the reference model by one clock edge with the current inputs.
  task automatic modelEdge(input logic fetch, input logic [1:0] mode, input logic [32:0] a);
    logic [31:0] nq;
    nq = mq;
    if (fetch && mode != 2'd0) begin
      case (mode)
        2'd1: nq = (mq << 1) + (a[31] ? 32'd0 : 32'd1);
        2'd2: nq = (mq >> 1) + (a[0] ? 32'h8000_0000 : 32'd0);
        default: nq = a[31:0];
      endcase
      hist.push_front(mq);
      if (hist.size() > 4) void'(hist.pop_back());
    end
    mq = nq;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".q"}, q, mq);
    checkOutput({tag, ".q_mf"}, q_mf, qdrive ? mq : 32'h0);
    checkOutput({tag, ".q_lsb"}, {31'h0, q_lsb}, {31'h0, mq[0]});
    checkOutput({tag, ".trace_cnt"}, {29'h0, trace_cnt}, expCnt());
    checkOutput({tag, ".trace_q"}, trace_q, expTrace(int'(trace_idx)));
  endtask

  // One microinstruction: drive at negedge, check pre-edge trace read,
  // clock it, then check everything just after the rising edge.
  task automatic applyStimulus(input logic fetch, input logic [1:0] mode,
                               input logic [32:0] a, input logic qd, input logic [1:0] idx);
    @(negedge clk);
    state_fetch = fetch;
    {qs1, qs0}  = mode;
    alu         = a;
    qdrive      = qd;
    trace_idx   = idx;
    #1;
    checkOutput("pre.trace_q", trace_q, expTrace(int'(idx)));
    @(posedge clk);
    modelEdge(fetch, mode, a);
    #1;
    checkAll("post");
  endtask

  initial begin
    logic [31:0] ring_exp [4];
    logic [31:0] zero_word;

    vecs[0] = '{1'b1, 2'd3, 33'h0_DEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0,        1'b1};
    vecs[1] = '{1'b0, 2'd0, 33'h0_00000000, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b1, 2'd3, 33'h0_80000001, 1'b0, 32'h80000001, 32'h0,        1'b1};
    vecs[3] = '{1'b1, 2'd1, 33'h0_00000000, 1'b1, 32'h00000003, 32'h00000003, 1'b1};
    vecs[4] = '{1'b1, 2'd2, 33'h0_00000001, 1'b1, 32'h80000001, 32'h80000001, 1'b1};
    vecs[5] = '{1'b0, 2'd3, 33'h0_12345678, 1'b0, 32'h80000001, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 2'd3, 33'h0_12345678, 1'b0, 32'h80000001, 32'h0,        1'b1};
    vecs[7] = '{1'b0, 2'd3, 33'h0_12345678, 1'b1, 32'h80000001, 32'h80000001, 1'b1};
    vecs[8] = '{1'b1, 2'd0, 33'h0_12345678, 1'b1, 32'h80000001, 32'h80000001, 1'b1};
    vecs[9] = '{1'b1, 2'd2, 33'h1_00000000, 1'b1, 32'h40000000, 32'h40000000, 1'b0};

    reset = 1'b1; state_fetch = 1'b0; qs0 = 1'b0; qs1 = 1'b0;
    qdrive = 1'b1; alu = '0; trace_idx = 2'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.q", q, 32'h0);
    checkOutput("rst.q_mf", q_mf, 32'h0);
    checkOutput("rst.trace_cnt", {29'h0, trace_cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: load, bus drive, shifts, strobe gating, hold strobe.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].fetch, vecs[i].mode, vecs[i].alu, vecs[i].qdrive, 2'd0);
      checkOutput($sformatf("vec%0d.q", i), q, vecs[i].exp_q);
      checkOutput($sformatf("vec%0d.q_mf", i), q_mf, vecs[i].exp_mf);
      checkOutput($sformatf("vec%0d.q_lsb", i), {31'h0, q_lsb}, {31'h0, vecs[i].exp_lsb});
    end

    // Ring wrap: from a fresh reset, load 1..5 and read back by age.
    @(negedge clk);
    reset = 1'b1; state_fetch = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      applyStimulus(1'b1, 2'd3, 33'(v), 1'b0, 2'd0);
    end
`ifdef Q_REG_TRACE_EN
    ring_exp = '{32'd4, 32'd3, 32'd2, 32'd1};
    checkOutput("wrap.cnt", {29'h0, trace_cnt}, 32'd4);
`else
    ring_exp = '{32'd0, 32'd0, 32'd0, 32'd0};
    checkOutput("wrap.cnt", {29'h0, trace_cnt}, 32'd0);
`endif
    checkOutput("wrap.q", q, 32'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      state_fetch = 1'b0;
      trace_idx = 2'(k);
      #1;
      checkOutput($sformatf("wrap.idx%0d", k), trace_q, ring_exp[k]);
    end
    applyStimulus(1'b1, 2'd0, 33'h0_FFFFFFFF, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      state_fetch = 1'b0;
      trace_idx = 2'(k);
      #1;
      checkOutput($sformatf("hold.idx%0d", k), trace_q, ring_exp[k]);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    {1'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)));
    end

    // Reset arriving together with a load strobe: everything clears at once
    // and the strobe is lost; the first strobe after release loads normally.
    applyStimulus(1'b1, 2'd3, 33'h0_CAFEF00D, 1'b1, 2'd0);
    @(negedge clk);
    state_fetch = 1'b1; qs1 = 1'b1; qs0 = 1'b1; alu = 33'h0_AAAA5555; qdrive = 1'b1;
    trace_idx = 2'd0;
    #3;
    reset = 1'b1;
    #1;
    zero_word = 32'h0;
    checkOutput("rstmid.q", q, zero_word);
    checkOutput("rstmid.q_mf", q_mf, zero_word);
    checkOutput("rstmid.trace_cnt", {29'h0, trace_cnt}, zero_word);
    checkOutput("rstmid.trace_q", trace_q, zero_word);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("rstmid.edge.q", q, zero_word);
    @(negedge clk);
    reset = 1'b0;
    state_fetch = 1'b0;
    applyStimulus(1'b1, 2'd3, 33'h0_5A5A5A5A, 1'b1, 2'd0);
    checkOutput("rstmid.reload", q, 32'h5A5A5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
